// File: rtl/ping_pong_pkg.sv
// Shared defaults, pixel type and control-FSM states for the ping-pong frame buffer.
package ping_pong_pkg;

    localparam int unsigned PIX_W_DEF = 8;
    localparam int unsigned H_BUF_DEF = 160;
    localparam int unsigned V_BUF_DEF = 120;
    localparam int unsigned SCALE_DEF = 2;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    typedef enum logic {
        ST_FILL    = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

endpackage

// File: rtl/pp_bank_ram.sv
// One frame bank: simple dual-port RAM, one write port, registered read gated by rd_en.
module pp_bank_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 19200,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A disabled read returns zero so the two banks can be OR-combined downstream.
    always_comb begin
        rd_data_d = '0;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ping_pong_swap_buffer.sv
// Double-buffered frame store: the writer fills the back bank, the display scans the
// front bank with integer upscaling, and banks swap at the start of vertical blanking.
module ping_pong_swap_buffer
    import ping_pong_pkg::*;
#(
    parameter  int unsigned PIX_W  = PIX_W_DEF,
    parameter  int unsigned H_BUF  = H_BUF_DEF,
    parameter  int unsigned V_BUF  = V_BUF_DEF,
    parameter  int unsigned SCALE  = SCALE_DEF,
    localparam int unsigned DEPTH  = H_BUF * V_BUF,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    output logic [PIX_W-1:0]  pixel_to_display,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              wr_done,
    output logic              swap_pending,
    output logic              front_sel,
    output logic [7:0]        frame_count
);

    localparam int unsigned VIS_H = H_BUF << SCALE;
    localparam int unsigned VIS_V = V_BUF << SCALE;

    state_e      state_q, state_d;
    logic        front_sel_q, front_sel_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        wr_ready_q, wr_ready_d;
    logic        swap_pending_q, swap_pending_d;

    logic              visible_c;
    logic              vblank_start_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              wr_fire_c;
    logic [PIX_W-1:0]  bank0_rd_data, bank1_rd_data;

    assign visible_c      = (hc < 10'(VIS_H)) && (vc < 10'(VIS_V));
    assign vblank_start_c = (hc == 10'd0) && (vc == 10'(VIS_V));

    // Row stride is a constant, so this maps to shifts/adds rather than a real multiplier.
    assign rd_addr_c = ADDR_W'(ADDR_W'(vc >> SCALE) * ADDR_W'(H_BUF)) + ADDR_W'(hc >> SCALE);

    // Out-of-range addresses are accepted on the handshake but never reach a bank.
    assign wr_fire_c = wr_valid && wr_ready_q && !rst && (32'(wr_addr) < DEPTH);

    pp_bank_ram #(.DATA_W(PIX_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_fire_c && front_sel_q),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (visible_c && !front_sel_q),
        .rd_addr (rd_addr_c),
        .rd_data (bank0_rd_data)
    );

    pp_bank_ram #(.DATA_W(PIX_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_fire_c && !front_sel_q),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (visible_c && front_sel_q),
        .rd_addr (rd_addr_c),
        .rd_data (bank1_rd_data)
    );

    // At most one bank read is enabled per cycle; the idle one outputs zero.
    assign pixel_to_display = bank0_rd_data | bank1_rd_data;

    always_comb begin
        state_d       = state_q;
        front_sel_d   = front_sel_q;
        frame_count_d = frame_count_q;
        case (state_q)
            ST_FILL: begin
                if (wr_done) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (vblank_start_c) begin
                    state_d       = ST_FILL;
                    front_sel_d   = !front_sel_q;
                    frame_count_d = frame_count_q + 8'd1;
                end
            end
            default: state_d = ST_FILL;
        endcase
        wr_ready_d     = (state_d == ST_FILL);
        swap_pending_d = (state_d == ST_PENDING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FILL;
            front_sel_q    <= 1'b0;
            frame_count_q  <= 8'd0;
            wr_ready_q     <= 1'b1;
            swap_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            front_sel_q    <= front_sel_d;
            frame_count_q  <= frame_count_d;
            wr_ready_q     <= wr_ready_d;
            swap_pending_q <= swap_pending_d;
        end
    end

    assign wr_ready     = wr_ready_q;
    assign swap_pending = swap_pending_q;
    assign front_sel    = front_sel_q;
    assign frame_count  = frame_count_q;

endmodule
